// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store has priority; a saturating starvation counter forces one fetch
// grant after STARVE_LIMIT consecutive load/store grants while fetch waits.
// Read responses return one cycle after the grant on mem_q.
module mem_arbiter #(
  parameter int WORD         = 32,
  parameter int ADDR         = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  // fetch port
  input  logic            if_req,
  input  logic [ADDR-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [WORD-1:0] if_rdata,
  // load/store port
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [ADDR-1:0] ls_addr,
  input  logic [WORD-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [WORD-1:0] ls_rdata,
  // shared synchronous memory
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2
  } owner_t;

  owner_t          state, state_nxt;
  logic [CW-1:0]   starve_cnt, starve_nxt;
  logic [ADDR-1:0] a_q;
  logic [WORD-1:0] d_q;
  logic            starve_ovr;

  // Grant decision: load/store first unless fetch has been starved too long
  always_comb begin
    starve_ovr = ~reset & if_req & ~if_flush & (starve_cnt == LIMIT);
    ls_gnt     = ls_req & ~reset & ~starve_ovr;
    if_gnt     = starve_ovr | (if_req & ~ls_req & ~if_flush & ~reset);
  end

  // Memory pin drive; address/data hold their last driven value when idle
  always_comb begin
    mem_a = a_q;
    mem_d = d_q;
    mem_w = 1'b0;
    if (if_gnt) begin
      mem_a = if_addr;
      mem_d = ls_wdata;
    end else if (ls_gnt) begin
      mem_a = ls_addr;
      mem_d = ls_wdata;
      mem_w = ls_we;
    end
  end

  // Next read owner and next starvation count
  always_comb begin
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    if (if_gnt)
      state_nxt = IF_RD;
    else if (ls_gnt && !ls_we)
      state_nxt = LS_RD;

    if (if_gnt || !if_req)
      starve_nxt = '0;
    else if (ls_gnt && starve_cnt != LIMIT)
      starve_nxt = starve_cnt + CW'(1);
  end

  // State, counter and held memory address/data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      a_q        <= mem_a;
      d_q        <= mem_d;
    end
  end

  // Responses: reset discards in-flight reads, flush discards fetch data
  always_comb begin
    ls_rvalid = ~reset & (state == LS_RD);
    if_rvalid = ~reset & (state == IF_RD) & ~if_flush;
    ls_rdata  = mem_q;
    if_rdata  = mem_q;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WORD, default 32, memory data width.
REQ-002 The block SHALL have parameter ADDR, default 16, memory word-address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, maximum number of consecutive load/store grants while fetch is waiting.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port if_req  input  1  fetch read request.
REQ-007 The block SHALL have port if_addr  input  ADDR  fetch read address.
REQ-008 The block SHALL have port if_flush  input  1  branch flush; discards fetch traffic.
REQ-009 The block SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-010 The block SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-011 The block SHALL have port if_rdata  output  WORD  fetch read data.
REQ-012 The block SHALL have port ls_req  input  1  load/store request.
REQ-013 The block SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-014 The block SHALL have port ls_addr  input  ADDR  load/store address.
REQ-015 The block SHALL have port ls_wdata  input  WORD  store data.
REQ-016 The block SHALL have port ls_gnt  output  1  load/store request accepted this cycle.
REQ-017 The block SHALL have port ls_rvalid  output  1  load data valid.
REQ-018 The block SHALL have port ls_rdata  output  WORD  load data.
REQ-019 The block SHALL have ports mem_a  output  ADDR, mem_w  output  1, mem_d  output  WORD, and mem_q  input  WORD, driving the A/W/D/Q pins of the single shared synchronous 32x64k memory.

Function
REQ-020 The memory SHALL be treated as one port; it samples A/W/D on a rising edge, and Q is valid throughout the following cycle.
REQ-021 At most one of if_gnt and ls_gnt SHALL be 1 in any cycle; grants are combinational from the current-cycle requests and state.
REQ-022 The default priority SHALL be load/store: ls_gnt = ls_req & ~reset.
REQ-023 The starvation override SHALL apply when starve_cnt == STARVE_LIMIT and if_req=1 and if_flush=0: if_gnt=1 and ls_gnt=0, so ls waits.
REQ-024 Otherwise if_gnt SHALL be if_req & ~ls_req & ~if_flush & ~reset.
REQ-025 starve_cnt SHALL be a counter of width clog2(STARVE_LIMIT+1). It increments, saturating at STARVE_LIMIT, when ls_gnt=1 and if_req=1 in the same cycle. It clears to 0 when if_gnt=1 or if_req=0.
REQ-026 Memory drive on a granted request SHALL be: mem_a = address of the granted requester; mem_w = ls_gnt & ls_we; mem_d = ls_wdata.
REQ-027 Memory drive with no grant SHALL be: mem_w = 0; mem_a and mem_d hold their last driven values, which requires a registered copy.
REQ-028 The in-flight read owner SHALL be a state register with states IDLE, IF_RD and LS_RD. It takes the next value on each edge as follows:
  - IF_RD if if_gnt;
  - LS_RD if ls_gnt & ~ls_we;
  - IDLE otherwise, including granted stores.
REQ-029 ls_rvalid SHALL be (state==LS_RD); ls_rdata SHALL be mem_q. Load latency is exactly 1 cycle after ls_gnt.
REQ-030 if_rvalid SHALL be (state==IF_RD) & ~if_flush; if_rdata SHALL be mem_q. A fetch response returning in a flush cycle is dropped.
REQ-031 if_flush SHALL NOT affect load/store grants, store writes or ls_rvalid.
REQ-032 The arbiter SHALL keep no request queue. A requester not granted holds req/addr/wdata stable and retries; ~gnt serves as its stall.
REQ-033 Back-to-back grants every cycle SHALL be supported, giving full throughput with one access per cycle.

Reset
REQ-034 While reset=1: if_gnt=0, ls_gnt=0, mem_w=0, if_rvalid=0, ls_rvalid=0.
REQ-035 On any edge with reset=1 the block SHALL set state to IDLE, starve_cnt to 0, and the registered mem_a/mem_d to 0.
REQ-036 Reset asserted while a read is in flight SHALL discard the response: no rvalid in the cycle after the reset edge.
REQ-037 The first grant SHALL be possible in the first cycle with reset=0.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x0000,0x0001,0x0002 on successive cycles -> if_gnt=1 each cycle; if_rvalid=1 one cycle later each time with if_rdata=mem[addr].
REQ-039 Store then load: ls_req=1, ls_we=1, ls_addr=0x0012, ls_wdata=0xDEADBEEF; next cycle load 0x0012 -> ls_rvalid=1 with 0xDEADBEEF; no ls_rvalid after the store.
REQ-040 Contention: if_req=1 and ls_req=1 held for 6 cycles (STARVE_LIMIT=4) -> ls_gnt for cycles 1-4, if_gnt in cycle 5, ls_gnt in cycle 6; starve_cnt back to 0 after cycle 5.
REQ-041 Flush: if_gnt for 0x0005, next cycle if_flush=1 with if_req=1 -> if_rvalid=0 and if_gnt=0 that cycle; a following request without flush returns normally.
REQ-042 Reset mid-read: ls load granted, reset=1 on the next edge -> ls_rvalid=0 and mem_w=0 while reset is held; state IDLE and starve_cnt=0 after release.
REQ-043 Idle: no requests for 3 cycles -> mem_w=0 and mem_a stable at its last value, with all gnt and rvalid outputs at 0.
